// File: rtl/swreg_table_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : swreg_table_loader                                           |
// | Description : Software-register command sequencer for a double-buffered    |
// |               lookup table: write/auto-increment, bulk fill, frame swap.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module swreg_table_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       cmd_word,
    input  logic              frame_sync,
    output logic              tbl_we,
    output logic [ADDR_W:0]   tbl_addr,
    output logic [DATA_W-1:0] tbl_din,
    output logic              active_bank,
    output logic [31:0]       status_out
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_swap = 2'd2;

    localparam logic [2:0] c_op_set_addr = 3'd1;
    localparam logic [2:0] c_op_write    = 3'd2;
    localparam logic [2:0] c_op_fill     = 3'd3;
    localparam logic [2:0] c_op_swap     = 3'd4;
    localparam logic [2:0] c_op_clr_err  = 3'd5;
    localparam logic [2:0] c_op_bad6     = 3'd6;
    localparam logic [2:0] c_op_bad7     = 3'd7;

    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_idx_one = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       r_cmd_q;
    logic              r_ack_tgl;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_fill_idx;
    logic              r_err;
    logic [11:0]       r_swap_cnt;

    logic              w_pending;
    logic              w_fill_done;
    logic              w_accept;
    logic              w_swap_now;
    logic              w_shadow;
    logic [2:0]        w_opcode;
    logic [23:0]       w_payload;
    logic [ADDR_W-1:0] w_ptr_base;
    logic [11:0]       w_ptr_ext;
    logic              w_unused_bits;

    assign w_opcode      = r_cmd_q[30:28];
    assign w_payload     = r_cmd_q[23:0];
    assign w_pending     = r_cmd_q[31] ^ r_ack_tgl;
    // The cycle showing the last fill write doubles as an IDLE slot for accepts.
    assign w_fill_done   = (r_state == c_st_fill) && r_fill_idx[ADDR_W];
    assign w_accept      = w_pending && ((r_state == c_st_idle) || w_fill_done);
    assign w_swap_now    = (r_state == c_st_swap) && frame_sync;
    assign w_shadow      = ~active_bank;
    assign w_ptr_base    = w_fill_done ? '0 : r_ptr;
    assign w_ptr_ext     = 12'(r_ptr);
    assign w_unused_bits = ^{r_cmd_q[27:24], w_payload};

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: w_state_nxt = c_st_idle;
            c_st_fill: if (w_fill_done) w_state_nxt = c_st_idle;
            c_st_swap: if (frame_sync) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        if (w_accept) begin
            case (w_opcode)
                c_op_fill: w_state_nxt = c_st_fill;
                c_op_swap: w_state_nxt = c_st_swap;
                default:   w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_comb begin
        status_out = {r_ack_tgl, (r_state != c_st_idle), (r_state == c_st_swap),
                      r_err, r_swap_cnt, 4'h0, w_ptr_ext};
    end

    // Sampling the live word into both cmd_q and ack_tgl at reset keeps a stale command from replaying.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_cmd_q     <= cmd_word;
            r_ack_tgl   <= cmd_word[31];
            active_bank <= 1'b0;
            r_ptr       <= '0;
            r_fill_idx  <= '0;
            r_err       <= 1'b0;
            r_swap_cnt  <= '0;
            tbl_we      <= 1'b0;
            tbl_addr    <= '0;
            tbl_din     <= '0;
        end else begin
            r_cmd_q <= cmd_word;
            tbl_we  <= 1'b0;

            if ((r_state == c_st_fill) && !r_fill_idx[ADDR_W]) begin
                tbl_we     <= 1'b1;
                tbl_addr   <= {w_shadow, r_fill_idx[ADDR_W-1:0]};
                r_fill_idx <= r_fill_idx + c_idx_one;
            end
            if (w_fill_done) begin
                r_ptr <= '0;
            end
            if (w_swap_now) begin
                active_bank <= ~active_bank;
                r_swap_cnt  <= r_swap_cnt + 12'd1;
            end

            if (w_accept) begin
                r_ack_tgl <= r_cmd_q[31];
                case (w_opcode)
                    c_op_set_addr: r_ptr <= w_payload[ADDR_W-1:0];
                    c_op_write: begin
                        tbl_we   <= 1'b1;
                        tbl_addr <= {w_shadow, w_ptr_base};
                        tbl_din  <= w_payload[DATA_W-1:0];
                        r_ptr    <= w_ptr_base + c_ptr_one;
                    end
                    // Index 0 is written at the accept edge; the FILL state covers the rest.
                    c_op_fill: begin
                        tbl_we     <= 1'b1;
                        tbl_addr   <= {w_shadow, {ADDR_W{1'b0}}};
                        tbl_din    <= w_payload[DATA_W-1:0];
                        r_fill_idx <= c_idx_one;
                    end
                    c_op_clr_err:         r_err <= 1'b0;
                    c_op_bad6, c_op_bad7: r_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_swreg_table_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_swreg_table_loader                                        |
// | Description : Self-checking bench for swreg_table_loader.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_swreg_table_loader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              user_clk = 1'b0;
    logic              user_rst;
    logic [31:0]       cmd_word;
    logic              frame_sync;
    logic              tbl_we;
    logic [ADDR_W:0]   tbl_addr;
    logic [DATA_W-1:0] tbl_din;
    logic              active_bank;
    logic [31:0]       status_out;

    always #5 user_clk = ~user_clk;

    swreg_table_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .cmd_word    (cmd_word),
        .frame_sync  (frame_sync),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_din     (tbl_din),
        .active_bank (active_bank),
        .status_out  (status_out)
    );

    typedef struct packed {
        logic [ADDR_W:0]   addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [2:0]        op;
        logic [23:0]       pl;
        logic              we;
        logic [ADDR_W:0]   addr;
        logic [DATA_W-1:0] din;
        logic [30:0]       st;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tgl;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    vec_t vecs[10];

    always @(negedge user_clk) begin
        if (tbl_we === 1'b1) obs_q.push_back({tbl_addr, tbl_din});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [23:0] pl);
        tgl      = ~tgl;
        cmd_word = {tgl, op, 4'h0, pl};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int base;
        int cyc;
        int m_ptr;
        int m_bank;
        int m_err;
        int m_swap;
        int r;
        logic [2:0]  op;
        logic [23:0] pl;
        wr_t o;
        wr_t e;

        vecs[0] = '{3'd1, 24'h0003FE, 1'b0, 11'h000, 24'h000000, 31'h0000_03FE};
        vecs[1] = '{3'd2, 24'hABCDEF, 1'b1, 11'h7FE, 24'hABCDEF, 31'h0000_03FF};
        vecs[2] = '{3'd2, 24'hABCDEF, 1'b1, 11'h7FF, 24'hABCDEF, 31'h0000_0000};
        vecs[3] = '{3'd7, 24'h123456, 1'b0, 11'h000, 24'h000000, 31'h1000_0000};
        vecs[4] = '{3'd0, 24'h00FFFF, 1'b0, 11'h000, 24'h000000, 31'h1000_0000};
        vecs[5] = '{3'd5, 24'h000000, 1'b0, 11'h000, 24'h000000, 31'h0000_0000};
        vecs[6] = '{3'd6, 24'h000001, 1'b0, 11'h000, 24'h000000, 31'h1000_0000};
        vecs[7] = '{3'd5, 24'h000000, 1'b0, 11'h000, 24'h000000, 31'h0000_0000};
        vecs[8] = '{3'd1, 24'h00F523, 1'b0, 11'h000, 24'h000000, 31'h0000_0123};
        vecs[9] = '{3'd2, 24'h000001, 1'b1, 11'h523, 24'h000001, 31'h0000_0124};

        // Reset with a stale toggled word present
        user_rst   = 1'b1;
        frame_sync = 1'b0;
        tgl        = 1'b1;
        cmd_word   = 32'h8000_0000;
        repeat (3) @(negedge user_clk);
        check("rst_status", status_out, 32'h8000_0000);
        check("rst_we", 32'(tbl_we), 32'd0);
        check("rst_addr", 32'(tbl_addr), 32'd0);
        check("rst_din", 32'(tbl_din), 32'd0);
        check("rst_bank", 32'(active_bank), 32'd0);
        user_rst = 1'b0;
        repeat (4) @(negedge user_clk);
        #1;
        check("no_replay_writes", 32'(obs_q.size()), 32'd0);
        check("post_rst_status", status_out, 32'h8000_0000);

        // Table-driven single commands: latency, write pulse width and status
        for (int i = 0; i < 10; i++) begin
            @(negedge user_clk);
            issue(vecs[i].op, vecs[i].pl);
            @(negedge user_clk);
            check($sformatf("vec%0d_we_early", i), 32'(tbl_we), 32'd0);
            @(negedge user_clk);
            check($sformatf("vec%0d_we", i), 32'(tbl_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("vec%0d_addr", i), 32'(tbl_addr), 32'(vecs[i].addr));
                check($sformatf("vec%0d_din", i), 32'(tbl_din), 32'(vecs[i].din));
            end
            @(negedge user_clk);
            check($sformatf("vec%0d_we_off", i), 32'(tbl_we), 32'd0);
            check($sformatf("vec%0d_status", i), status_out, {tgl, vecs[i].st});
        end

        // FILL with a WRITE queued behind it
        @(negedge user_clk);
        issue(3'd3, 24'h000055);
        @(negedge user_clk);
        issue(3'd2, 24'h000077);
        @(negedge user_clk);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(tbl_we === 1'b1 && tbl_addr === {1'b1, ADDR_W'(i)} &&
                  tbl_din === 24'h000055 && status_out[30] === 1'b1)) begin
                if (bad == 0)
                    $display("fill cycle %0d: we=%b addr=0x%h din=0x%h busy=%b, want we=1 addr=0x%h din=0x000055 busy=1",
                             i, tbl_we, tbl_addr, tbl_din, status_out[30], {1'b1, ADDR_W'(i)});
                bad++;
            end
            @(negedge user_clk);
        end
        check("fill_bad_cycles", 32'(bad), 32'd0);
        check("queued_wr_we", 32'(tbl_we), 32'd1);
        check("queued_wr_addr", 32'(tbl_addr), 32'h400);
        check("queued_wr_din", 32'(tbl_din), 32'h77);
        check("queued_wr_busy", 32'(status_out[30]), 32'd0);
        @(negedge user_clk);
        check("after_fill_we", 32'(tbl_we), 32'd0);
        check("after_fill_status", status_out, {tgl, 31'h0000_0001});

        // SWAP: frame_sync on the accept edge is ignored, the later one swaps
        issue(3'd4, 24'h0);
        @(negedge user_clk);
        frame_sync = 1'b1;
        @(negedge user_clk);
        frame_sync = 1'b0;
        check("swap_pending_early", 32'(status_out[30:29]), 32'd3);
        check("swap_bank_early", 32'(active_bank), 32'd0);
        repeat (3) @(negedge user_clk);
        check("swap_pending_held", 32'(status_out[29]), 32'd1);
        check("swap_bank_held", 32'(active_bank), 32'd0);
        frame_sync = 1'b1;
        @(negedge user_clk);
        frame_sync = 1'b0;
        check("swap_bank", 32'(active_bank), 32'd1);
        check("swap_status", status_out, {tgl, 31'h0001_0001});
        issue(3'd2, 24'h0000AA);
        repeat (2) @(negedge user_clk);
        check("post_swap_we", 32'(tbl_we), 32'd1);
        check("post_swap_addr", 32'(tbl_addr), 32'h001);
        check("post_swap_din", 32'(tbl_din), 32'hAA);
        frame_sync = 1'b1;
        @(negedge user_clk);
        frame_sync = 1'b0;
        @(negedge user_clk);
        check("idle_sync_bank", 32'(active_bank), 32'd1);
        check("idle_sync_cnt", 32'(status_out[27:16]), 32'd1);

        // Reset roughly 100 cycles into a FILL
        issue(3'd3, 24'h000033);
        repeat (102) @(negedge user_clk);
        check("midfill_we", 32'(tbl_we), 32'd1);
        check("midfill_busy", 32'(status_out[30]), 32'd1);
        user_rst = 1'b1;
        @(negedge user_clk);
        user_rst = 1'b0;
        check("abort_we", 32'(tbl_we), 32'd0);
        check("abort_status", status_out, {tgl, 31'h0});
        check("abort_bank", 32'(active_bank), 32'd0);
        #1;
        base = obs_q.size();
        repeat (5) @(negedge user_clk);
        #1;
        check("abort_no_writes", 32'(obs_q.size() - base), 32'd0);
        check("abort_status_held", status_out, {tgl, 31'h0});

        // Randomised commands against a transaction-level model
        obs_q.delete();
        m_ptr  = 0;
        m_bank = 0;
        m_err  = 0;
        m_swap = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge user_clk);
            if ($urandom_range(0, 3) == 0) begin
                frame_sync = 1'b1;
                @(negedge user_clk);
                frame_sync = 1'b0;
                @(negedge user_clk);
            end
            r  = $urandom_range(0, 15);
            op = (r < 2) ? 3'd0 : (r < 5) ? 3'd1 : (r < 10) ? 3'd2 : (r == 10) ? 3'd3 :
                 (r < 13) ? 3'd4 : (r == 13) ? 3'd5 : (r == 14) ? 3'd6 : 3'd7;
            pl = 24'($urandom());
            issue(op, pl);

            case (op)
                3'd1: m_ptr = int'(pl) % DEPTH;
                3'd2: begin
                    exp_q.push_back({(m_bank == 0) ? 1'b1 : 1'b0, ADDR_W'(m_ptr), pl});
                    m_ptr = (m_ptr + 1) % DEPTH;
                end
                3'd3: begin
                    for (int i = 0; i < DEPTH; i++)
                        exp_q.push_back({(m_bank == 0) ? 1'b1 : 1'b0, ADDR_W'(i), pl});
                    m_ptr = 0;
                end
                3'd4: begin
                    m_bank = 1 - m_bank;
                    m_swap = (m_swap + 1) % 4096;
                end
                3'd5: m_err = 0;
                3'd6, 3'd7: m_err = 1;
                default: ;
            endcase

            cyc = 0;
            @(negedge user_clk);
            while (status_out[31] !== tgl && cyc < 50) begin
                @(negedge user_clk);
                cyc++;
            end
            check($sformatf("rand%0d_ack", n), 32'(status_out[31]), 32'(tgl));
            if (op == 3'd4) begin
                repeat ($urandom_range(0, 4)) @(negedge user_clk);
                frame_sync = 1'b1;
                @(negedge user_clk);
                frame_sync = 1'b0;
            end
            cyc = 0;
            while (status_out[30] !== 1'b0 && cyc < 2000) begin
                @(negedge user_clk);
                cyc++;
            end
            @(negedge user_clk);
            #1;
            check($sformatf("rand%0d_status", n), status_out,
                  {tgl, 2'b00, 1'(m_err), 12'(m_swap), 4'h0, 12'(m_ptr)});
            check($sformatf("rand%0d_bank", n), 32'(active_bank), 32'(m_bank));
            check($sformatf("rand%0d_wr_count", n), 32'(obs_q.size()), 32'(exp_q.size()));
            bad = 0;
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o !== e) begin
                    if (bad == 0)
                        $display("rand%0d write: got addr=0x%h data=0x%h, want addr=0x%h data=0x%h",
                                 n, o.addr, o.data, e.addr, e.data);
                    bad++;
                end
            end
            obs_q.delete();
            exp_q.delete();
            check($sformatf("rand%0d_wr_data", n), 32'(bad), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
